udp_line_packetizer: RTL



---
 rtl/udp_pkg.sv | 29 ++
 rtl/udp_line_packetizer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/udp_pkg.sv
// Shared constants and state encoding for the udp_send feeder path.
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  localparam int HDR_BYTES      = 4;
  localparam int UDP_FIFO_DEPTH = 4096;
  localparam int USAGE_W        = 12;
  localparam int FREE_W         = USAGE_W + 1;
  localparam int IDX_W          = 12;

  // Free FIFO space; clamps at zero instead of wrapping when usage is at or past depth-1.
  function automatic logic [FREE_W-1:0] fifo_free(input logic [USAGE_W-1:0] usage,
                                                  input int depth);
    logic [FREE_W-1:0] top;
    logic [FREE_W-1:0] used;
    top  = FREE_W'(depth - 1);
    used = {1'b0, usage};
    return (used >= top) ? '0 : top - used;
  endfunction

endpackage

// File: rtl/udp_line_packetizer.sv
// Cuts a pixel byte stream into header+line packets for the udp_send payload FIFO.
// Pixel handshake: a byte moves only in a cycle where pix_valid and pix_ready are both high.
module udp_line_packetizer
  import udp_pkg::*;
#(
  parameter int LINE_BYTES  = 1280,
  parameter int FIFO_DEPTH  = UDP_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic               clk_125m,
  input  logic               reset_n,
  input  logic [7:0]         pix_data,
  input  logic               pix_valid,
  input  logic               pix_sof,
  output logic               pix_ready,
  output logic [7:0]         fifo_write_data,
  output logic               fifo_write_request,
  input  logic [USAGE_W-1:0] fifo_write_usage,
  output logic [15:0]        data_length,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               sync_err,
  output logic               tx_timeout
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_BYTES - 1);
  localparam logic [FREE_W-1:0] PKT_SPACE = FREE_W'(LINE_BYTES + HDR_BYTES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]       PKT_LEN   = 16'(LINE_BYTES + HDR_BYTES);

  state_t             state, state_nxt;
  logic [15:0]        frame_cnt, frame_nxt;
  logic [15:0]        line_cnt, line_nxt;
  logic [IDX_W-1:0]   byte_idx, idx_nxt;
  logic               seen_sof, seen_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [FREE_W-1:0]  free_space;
  logic               sof_hold;

  always_ff @(posedge clk_125m or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      line_cnt    <= '0;
      byte_idx    <= '0;
      seen_sof    <= 1'b0;
      tmo_cnt     <= '0;
      data_length <= PKT_LEN;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_nxt;
      line_cnt    <= line_nxt;
      byte_idx    <= idx_nxt;
      seen_sof    <= seen_nxt;
      tmo_cnt     <= tmo_nxt;
      data_length <= PKT_LEN;
    end
  end

  always_comb begin
    state_nxt          = state;
    frame_nxt          = frame_cnt;
    line_nxt           = line_cnt;
    idx_nxt            = byte_idx;
    seen_nxt           = seen_sof;
    tmo_nxt            = tmo_cnt;
    pix_ready          = 1'b0;
    fifo_write_request = 1'b0;
    fifo_write_data    = 8'h00;
    tx_start           = 1'b0;
    sync_err           = 1'b0;
    tx_timeout         = 1'b0;
    free_space         = fifo_free(fifo_write_usage, FIFO_DEPTH);
    // A new frame start inside a line means the line came up short.
    sof_hold           = pix_valid && pix_sof && (byte_idx != '0);

    case (state)
      ST_IDLE: begin
        if (pix_valid && (free_space >= PKT_SPACE)) begin
          state_nxt = ST_HDR;
          idx_nxt   = '0;
          if (pix_sof) begin
            line_nxt = '0;
            seen_nxt = 1'b1;
            if (seen_sof) frame_nxt = frame_cnt + 16'd1;
          end
        end
      end
      ST_HDR: begin
        fifo_write_request = 1'b1;
        case (byte_idx[1:0])
          2'd0: fifo_write_data = frame_cnt[15:8];
          2'd1: fifo_write_data = frame_cnt[7:0];
          2'd2: fifo_write_data = line_cnt[15:8];
          2'd3: fifo_write_data = line_cnt[7:0];
        endcase
        if (byte_idx[1:0] == 2'd3) begin
          idx_nxt   = '0;
          state_nxt = ST_PAYLOAD;
        end else begin
          idx_nxt = byte_idx + IDX_W'(1);
        end
      end
      ST_PAYLOAD: begin
        if (sof_hold) begin
          sync_err  = 1'b1;
          state_nxt = ST_PAD;
        end else begin
          pix_ready = 1'b1;
          if (pix_valid) begin
            fifo_write_request = 1'b1;
            fifo_write_data    = pix_data;
            idx_nxt            = byte_idx + IDX_W'(1);
            if (byte_idx == LAST_IDX) state_nxt = ST_SEND;
          end
        end
      end
      ST_PAD: begin
        fifo_write_request = 1'b1;
        idx_nxt            = byte_idx + IDX_W'(1);
        if (byte_idx == LAST_IDX) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        tx_start  = 1'b1;
        tmo_nxt   = '0;
        state_nxt = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // tx_done wins over a timeout expiring in the same cycle.
        if (tx_done) begin
          line_nxt  = line_cnt + 16'd1;
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tx_timeout = 1'b1;
          line_nxt   = line_cnt + 16'd1;
          state_nxt  = ST_IDLE;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
